// File: rtl/kinase_assay_sequencer.sv
// kinase_assay_sequencer
//
// Protocol controller for the kinase-activity chip control pads. One assay
// runs per start: LOAD_A, LOAD_B, LOAD_C, optional MIX, INCUBATE, ELUTE,
// FLUSH, DONE, then back to IDLE. Durations are counted in ticks of a
// TICK_DIV-clock prescaler. The prescaler, tick counter and pump phases
// restart on every state entry, so a state of N ticks lasts N*TICK_DIV clocks.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           begin an assay (sampled in IDLE only)
//   abort           jump to FLUSH from LOAD_A..ELUTE
//   cfg_mix_cycles  ring pump revolutions (6 ticks each), captured at start
//   cfg_out_sel     output port 0..3, captured at start
//   busy, done      status; done is a one-cycle pulse in DONE
//   state_o         current state code
//   pad_ctrl_a      13 chip valves (1 = closed)
//   pad_ctrl_s      4 output-select valves (1 = closed)
//   pad_pump_a      3-valve inlet peristaltic pump
//   pad_pump_b      2-valve ring pump
//
// All outputs are registered and always equal the decode of the state and
// pump phase being loaded on the same edge.
module kinase_assay_sequencer #(
    parameter int TICK_DIV    = 1000,
    parameter int LOAD_TICKS  = 48,
    parameter int INC_TICKS   = 200,
    parameter int ELUTE_TICKS = 48,
    parameter int FLUSH_TICKS = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  cfg_mix_cycles,
    input  logic [1:0]  cfg_out_sel,
    output logic        busy,
    output logic        done,
    output logic [3:0]  state_o,
    output logic [12:0] pad_ctrl_a,
    output logic [3:0]  pad_ctrl_s,
    output logic [2:0]  pad_pump_a,
    output logic [1:0]  pad_pump_b
);

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_LOAD_A   = 4'd1;
    localparam logic [3:0] ST_LOAD_B   = 4'd2;
    localparam logic [3:0] ST_LOAD_C   = 4'd3;
    localparam logic [3:0] ST_MIX      = 4'd4;
    localparam logic [3:0] ST_INCUBATE = 4'd5;
    localparam logic [3:0] ST_ELUTE    = 4'd6;
    localparam logic [3:0] ST_FLUSH    = 4'd7;
    localparam logic [3:0] ST_DONE     = 4'd8;

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    // Wide enough for 6*255 mix ticks as well as the fixed state durations.
    localparam int TCNT_W = 16;

    logic [3:0]        state_r;
    logic [PRE_W-1:0]  pre_r;
    logic [TCNT_W-1:0] tcnt_r;
    logic [2:0]        pha_r;
    logic              phb_r;
    logic [7:0]        mix_r;
    logic [1:0]        sel_r;

    logic [3:0]        nxt_state;
    logic [PRE_W-1:0]  nxt_pre;
    logic [TCNT_W-1:0] nxt_tcnt;
    logic [2:0]        nxt_pha;
    logic              nxt_phb;
    logic [7:0]        nxt_mix;
    logic [1:0]        nxt_sel;
    logic [TCNT_W-1:0] limit;
    logic              tick;
    logic              last_tick;
    logic              clear;
    logic              abortable;

    // ---------------- output decode ----------------
    function automatic logic [12:0] ctrl_a_dec(input logic [3:0] st);
        case (st)
            ST_LOAD_A: ctrl_a_dec = 13'h1DE6;
            ST_LOAD_B: ctrl_a_dec = 13'h1DE5;
            ST_LOAD_C,
            ST_FLUSH:  ctrl_a_dec = 13'h1DE3;
            ST_MIX:    ctrl_a_dec = 13'h1E1F;
            ST_ELUTE:  ctrl_a_dec = 13'h1E0F;
            default:   ctrl_a_dec = 13'h1FFF;
        endcase
    endfunction

    function automatic logic [3:0] ctrl_s_dec(input logic [3:0] st, input logic [1:0] sel);
        if (st == ST_ELUTE) ctrl_s_dec = ~(4'b0001 << sel);
        else                ctrl_s_dec = 4'hF;
    endfunction

    function automatic logic [2:0] pump_a_dec(input logic [3:0] st, input logic [2:0] ph);
        logic [2:0] pat;
        case (ph)
            3'd0:    pat = 3'b011;
            3'd1:    pat = 3'b001;
            3'd2:    pat = 3'b101;
            3'd3:    pat = 3'b100;
            3'd4:    pat = 3'b110;
            default: pat = 3'b010;
        endcase
        if (st == ST_LOAD_A || st == ST_LOAD_B || st == ST_LOAD_C || st == ST_FLUSH)
            pump_a_dec = pat;
        else
            pump_a_dec = 3'b111;
    endfunction

    function automatic logic [1:0] pump_b_dec(input logic [3:0] st, input logic ph);
        if (st == ST_MIX || st == ST_ELUTE) pump_b_dec = ph ? 2'b10 : 2'b01;
        else                                pump_b_dec = 2'b11;
    endfunction

    // ---------------- tick and duration ----------------
    assign tick = (pre_r == PRE_W'(TICK_DIV - 1));

    always_comb begin
        limit = TCNT_W'(1);
        case (state_r)
            ST_LOAD_A,
            ST_LOAD_B,
            ST_LOAD_C:   limit = TCNT_W'(LOAD_TICKS);
            ST_MIX:      limit = TCNT_W'(mix_r) * TCNT_W'(6);
            ST_INCUBATE: limit = TCNT_W'(INC_TICKS);
            ST_ELUTE:    limit = TCNT_W'(ELUTE_TICKS);
            ST_FLUSH:    limit = TCNT_W'(FLUSH_TICKS);
            default:     limit = TCNT_W'(1);
        endcase
    end

    assign last_tick = tick && (tcnt_r == limit - TCNT_W'(1));
    assign abortable = (state_r >= ST_LOAD_A) && (state_r <= ST_ELUTE);

    // ---------------- next state ----------------
    always_comb begin
        nxt_state = state_r;
        case (state_r)
            ST_IDLE:     if (start) nxt_state = ST_LOAD_A;
            ST_LOAD_A:   if (last_tick) nxt_state = ST_LOAD_B;
            ST_LOAD_B:   if (last_tick) nxt_state = ST_LOAD_C;
            ST_LOAD_C:   if (last_tick) nxt_state = (mix_r == 8'd0) ? ST_INCUBATE : ST_MIX;
            ST_MIX:      if (last_tick) nxt_state = ST_INCUBATE;
            ST_INCUBATE: if (last_tick) nxt_state = ST_ELUTE;
            ST_ELUTE:    if (last_tick) nxt_state = ST_FLUSH;
            ST_FLUSH:    if (last_tick) nxt_state = ST_DONE;
            ST_DONE:     nxt_state = ST_IDLE;
            default:     nxt_state = ST_IDLE;
        endcase
        if (abort && abortable) nxt_state = ST_FLUSH;
    end

    // Counters restart on every state change and stay parked at zero in IDLE.
    assign clear = (nxt_state != state_r) || (state_r == ST_IDLE);

    always_comb begin
        nxt_pre  = '0;
        nxt_tcnt = '0;
        nxt_pha  = 3'd0;
        nxt_phb  = 1'b0;
        if (!clear) begin
            nxt_pre  = tick ? '0 : pre_r + PRE_W'(1);
            nxt_tcnt = tick ? tcnt_r + TCNT_W'(1) : tcnt_r;
            nxt_pha  = pha_r;
            nxt_phb  = phb_r;
            if (tick) begin
                nxt_pha = (pha_r == 3'd5) ? 3'd0 : pha_r + 3'd1;
                nxt_phb = ~phb_r;
            end
        end
    end

    // Configuration is captured only on the start that leaves IDLE.
    assign nxt_mix = (state_r == ST_IDLE && start) ? cfg_mix_cycles : mix_r;
    assign nxt_sel = (state_r == ST_IDLE && start) ? cfg_out_sel    : sel_r;

    // ---------------- state and output registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            pre_r      <= '0;
            tcnt_r     <= '0;
            pha_r      <= 3'd0;
            phb_r      <= 1'b0;
            mix_r      <= 8'd0;
            sel_r      <= 2'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            state_o    <= ST_IDLE;
            pad_ctrl_a <= 13'h1FFF;
            pad_ctrl_s <= 4'hF;
            pad_pump_a <= 3'b111;
            pad_pump_b <= 2'b11;
        end else begin
            state_r    <= nxt_state;
            pre_r      <= nxt_pre;
            tcnt_r     <= nxt_tcnt;
            pha_r      <= nxt_pha;
            phb_r      <= nxt_phb;
            mix_r      <= nxt_mix;
            sel_r      <= nxt_sel;
            busy       <= (nxt_state != ST_IDLE);
            done       <= (nxt_state == ST_DONE);
            state_o    <= nxt_state;
            pad_ctrl_a <= ctrl_a_dec(nxt_state);
            pad_ctrl_s <= ctrl_s_dec(nxt_state, nxt_sel);
            pad_pump_a <= pump_a_dec(nxt_state, nxt_pha);
            pad_pump_b <= pump_b_dec(nxt_state, nxt_phb);
        end
    end

endmodule

// File: tb/tb_kinase_assay_sequencer.sv
// Bench for kinase_assay_sequencer with short timing overrides
// (TICK_DIV=2, LOAD=3, INC=4, ELUTE=3, FLUSH=2). Stimulus pushes expected
// output snapshots tagged with the clock edge after which they must hold; a
// monitor samples on every falling edge and compares when a tag comes due.
module tb_kinase_assay_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [7:0]  cfg_mix_cycles;
    logic [1:0]  cfg_out_sel;
    logic        busy;
    logic        done;
    logic [3:0]  state_o;
    logic [12:0] pad_ctrl_a;
    logic [3:0]  pad_ctrl_s;
    logic [2:0]  pad_pump_a;
    logic [1:0]  pad_pump_b;

    kinase_assay_sequencer #(
        .TICK_DIV(2), .LOAD_TICKS(3), .INC_TICKS(4), .ELUTE_TICKS(3), .FLUSH_TICKS(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_mix_cycles(cfg_mix_cycles), .cfg_out_sel(cfg_out_sel),
        .busy(busy), .done(done), .state_o(state_o),
        .pad_ctrl_a(pad_ctrl_a), .pad_ctrl_s(pad_ctrl_s),
        .pad_pump_a(pad_pump_a), .pad_pump_b(pad_pump_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic [27:0] v;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   no_mix   = 1'b0;

    // {state, ctrl_a, ctrl_s, pump_a, pump_b, busy, done}
    task automatic push(input int c, input logic [3:0] st, input logic [12:0] a,
                        input logic [3:0] s, input logic [2:0] pa, input logic [1:0] pb,
                        input logic b, input logic d);
        exp_t e;
        e.c = c;
        e.v = {st, a, s, pa, pb, b, d};
        q.push_back(e);
    endtask

    task automatic push_idle(input int c);
        push(c, 4'd0, 13'h1FFF, 4'hF, 3'b111, 2'b11, 1'b0, 1'b0);
    endtask

    // Hand-derived timeline of a complete assay whose start is sampled at edge e.
    task automatic push_full(input int e, input int mix, input logic [1:0] sel, output int fin);
        logic [3:0] so;
        int m, i, el, f, d;
        so = ~(4'b0001 << sel);
        push(e,    4'd1, 13'h1DE6, 4'hF, 3'b011, 2'b11, 1'b1, 1'b0);
        push(e+1,  4'd1, 13'h1DE6, 4'hF, 3'b011, 2'b11, 1'b1, 1'b0);
        push(e+2,  4'd1, 13'h1DE6, 4'hF, 3'b001, 2'b11, 1'b1, 1'b0);
        push(e+4,  4'd1, 13'h1DE6, 4'hF, 3'b101, 2'b11, 1'b1, 1'b0);
        push(e+5,  4'd1, 13'h1DE6, 4'hF, 3'b101, 2'b11, 1'b1, 1'b0);
        push(e+6,  4'd2, 13'h1DE5, 4'hF, 3'b011, 2'b11, 1'b1, 1'b0);
        push(e+8,  4'd2, 13'h1DE5, 4'hF, 3'b001, 2'b11, 1'b1, 1'b0);
        push(e+12, 4'd3, 13'h1DE3, 4'hF, 3'b011, 2'b11, 1'b1, 1'b0);
        m = e + 18;
        if (mix != 0) begin
            push(m,    4'd4, 13'h1E1F, 4'hF, 3'b111, 2'b01, 1'b1, 1'b0);
            push(m+2,  4'd4, 13'h1E1F, 4'hF, 3'b111, 2'b10, 1'b1, 1'b0);
            push(m+11, 4'd4, 13'h1E1F, 4'hF, 3'b111, 2'b10, 1'b1, 1'b0);
            i = m + 12;
        end else begin
            i = m;
        end
        push(i,   4'd5, 13'h1FFF, 4'hF, 3'b111, 2'b11, 1'b1, 1'b0);
        push(i+7, 4'd5, 13'h1FFF, 4'hF, 3'b111, 2'b11, 1'b1, 1'b0);
        el = i + 8;
        push(el,   4'd6, 13'h1E0F, so, 3'b111, 2'b01, 1'b1, 1'b0);
        push(el+2, 4'd6, 13'h1E0F, so, 3'b111, 2'b10, 1'b1, 1'b0);
        push(el+5, 4'd6, 13'h1E0F, so, 3'b111, 2'b01, 1'b1, 1'b0);
        f = el + 6;
        push(f,   4'd7, 13'h1DE3, 4'hF, 3'b011, 2'b11, 1'b1, 1'b0);
        push(f+2, 4'd7, 13'h1DE3, 4'hF, 3'b001, 2'b11, 1'b1, 1'b0);
        push(f+3, 4'd7, 13'h1DE3, 4'hF, 3'b001, 2'b11, 1'b1, 1'b0);
        d = f + 4;
        push(d, 4'd8, 13'h1FFF, 4'hF, 3'b111, 2'b11, 1'b1, 1'b1);
        push_idle(d + 1);
        fin = d + 1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [27:0] act;
        act = {state_o, pad_ctrl_a, pad_ctrl_s, pad_pump_a, pad_pump_b, busy, done};
        if (no_mix) begin
            checks++;
            if (state_o == 4'd4) begin
                failures++;
                $display("FAIL no_mix_state cyc=%0d state_o=%0d must not be 4", cyc, state_o);
            end
        end
        while (q.size() > 0 && q[0].c < cyc) begin
            checks++;
            failures++;
            $display("FAIL missed_sample cyc=%0d tag=%0d", cyc, q[0].c);
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].c == cyc) begin
            checks++;
            if (act !== q[0].v) begin
                failures++;
                $display("FAIL snapshot cyc=%0d got st=%0d a=%h s=%h pa=%b pb=%b busy=%b done=%b exp st=%0d a=%h s=%h pa=%b pb=%b busy=%b done=%b",
                         cyc, act[27:24], act[23:11], act[10:7], act[6:4], act[3:2], act[1], act[0],
                         q[0].v[27:24], q[0].v[23:11], q[0].v[10:7], q[0].v[6:4], q[0].v[3:2],
                         q[0].v[1], q[0].v[0]);
            end
            void'(q.pop_front());
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Drives start for the next edge; returns the number of that edge.
    task automatic kick(input logic [7:0] mix, input logic [1:0] sel, input logic ab, output int e);
        @(negedge clk);
        cfg_mix_cycles = mix;
        cfg_out_sel    = sel;
        start          = 1'b1;
        abort          = ab;
        e              = cyc + 1;
    endtask

    task automatic release_inputs();
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int e, fin;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_mix_cycles = 8'd0; cfg_out_sel = 2'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        push_idle(cyc);
        push_idle(cyc + 1);
        @(negedge clk);

        // Full run, mix=1, out_sel=2; a stray start mid-run must not disturb it.
        kick(8'd1, 2'd2, 1'b0, e);
        push_full(e, 1, 2'd2, fin);
        release_inputs();
        wait_until(e + 9);
        start = 1'b1; cfg_out_sel = 2'd0; cfg_mix_cycles = 8'd0;
        @(negedge clk);
        start = 1'b0;
        wait_until(fin + 1);

        // abort in IDLE has no effect
        abort = 1'b1;
        push_idle(cyc + 1);
        push_idle(cyc + 2);
        @(negedge clk);
        @(negedge clk);
        abort = 1'b0;

        // mix=0 skips MIX
        no_mix = 1'b1;
        kick(8'd0, 2'd0, 1'b0, e);
        push_full(e, 0, 2'd0, fin);
        release_inputs();
        wait_until(fin + 1);
        no_mix = 1'b0;

        // abort inside MIX
        kick(8'd1, 2'd1, 1'b0, e);
        push(e,    4'd1, 13'h1DE6, 4'hF, 3'b011, 2'b11, 1'b1, 1'b0);
        push(e+18, 4'd4, 13'h1E1F, 4'hF, 3'b111, 2'b01, 1'b1, 1'b0);
        push(e+19, 4'd4, 13'h1E1F, 4'hF, 3'b111, 2'b01, 1'b1, 1'b0);
        push(e+20, 4'd7, 13'h1DE3, 4'hF, 3'b011, 2'b11, 1'b1, 1'b0);
        push(e+22, 4'd7, 13'h1DE3, 4'hF, 3'b001, 2'b11, 1'b1, 1'b0);
        push(e+24, 4'd8, 13'h1FFF, 4'hF, 3'b111, 2'b11, 1'b1, 1'b1);
        push_idle(e + 25);
        release_inputs();
        wait_until(e + 19);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_until(e + 26);

        // start and abort together in IDLE: start wins
        kick(8'd1, 2'd3, 1'b1, e);
        push_full(e, 1, 2'd3, fin);
        release_inputs();
        wait_until(fin + 1);

        // reset during INCUBATE, then a clean run
        kick(8'd0, 2'd1, 1'b0, e);
        push(e,    4'd1, 13'h1DE6, 4'hF, 3'b011, 2'b11, 1'b1, 1'b0);
        push(e+18, 4'd5, 13'h1FFF, 4'hF, 3'b111, 2'b11, 1'b1, 1'b0);
        push(e+19, 4'd5, 13'h1FFF, 4'hF, 3'b111, 2'b11, 1'b1, 1'b0);
        push_idle(e + 20);
        release_inputs();
        wait_until(e + 19);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        push_idle(cyc + 1);
        @(negedge clk);
        kick(8'd1, 2'd1, 1'b0, e);
        push_full(e, 1, 2'd1, fin);
        release_inputs();
        wait_until(fin + 2);

        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain pending=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
